// File: rtl/idc_pkg.sv
// Shared types and constants for the ID-checker scheduler.
package idc_pkg;
  localparam int ID_W      = 6;
  localparam int CNT_W     = 4;
  localparam int OWN_W     = 3;
  localparam int N_SYM_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    RESP
  } state_e;
endpackage

// File: rtl/idc_rr_pick.sv
// Combinational round-robin picker: first set request after last_owner_i, wrapping.
module idc_rr_pick
  import idc_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [OWN_W-1:0] last_owner_i,
  output logic [OWN_W-1:0] winner_o,
  output logic             found_o
);

  always_comb begin
    int unsigned idx;
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(last_owner_i) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found_o && i == idx && req_i[i]) begin
          found_o  = 1'b1;
          winner_o = OWN_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/idc_sched.sv
// Arbitrates N_REQ symbol streams onto one shared ID checker, one frame at a time,
// and returns the checker verdict (or a timeout error) tagged with the owner.
module idc_sched
  import idc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_SYM   = N_SYM_DEF,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      in_valid,
  input  logic [ID_W*N_REQ-1:0] in_id,
  output logic [N_REQ-1:0]      grant,
  output logic                  chk_in_valid,
  output logic [ID_W-1:0]       chk_in_id,
  input  logic                  chk_out_valid,
  input  logic                  chk_out_legal_id,
  output logic                  out_valid,
  output logic [OWN_W-1:0]      out_owner,
  output logic                  out_legal_id,
  output logic                  out_err
);

  localparam logic [CNT_W-1:0] LAST_SYM  = CNT_W'(N_SYM - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TIMEOUT - 1);
  localparam logic [OWN_W-1:0] RST_OWNER = OWN_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               chk_v_q, chk_v_d;
  logic [ID_W-1:0]    chk_id_q, chk_id_d;
  logic               out_v_q, out_v_d;
  logic [OWN_W-1:0]   out_own_q, out_own_d;
  logic               out_legal_q, out_legal_d;
  logic               out_err_q, out_err_d;

  logic [OWN_W-1:0]   winner;
  logic               found;
  logic               cur_valid;
  logic [ID_W-1:0]    cur_id;

  idc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i       (req),
    .last_owner_i(last_owner_q),
    .winner_o    (winner),
    .found_o     (found)
  );

  // Select the granted requester's lane; other lanes never reach the checker.
  always_comb begin
    cur_valid = 1'b0;
    cur_id    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == OWN_W'(i)) begin
        cur_valid = in_valid[i];
        cur_id    = in_id[i*ID_W +: ID_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    chk_v_d      = 1'b0;
    chk_id_d     = '0;
    out_v_d      = 1'b0;
    out_own_d    = '0;
    out_legal_d  = 1'b0;
    out_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = STREAM;
          owner_d = winner;
          cnt_d   = '0;
          for (int unsigned i = 0; i < N_REQ; i++) grant_d[i] = (winner == OWN_W'(i));
        end
      end
      STREAM: begin
        chk_v_d  = cur_valid;
        chk_id_d = cur_id;
        if (cur_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SYM) begin
            grant_d = '0;
            timer_d = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // The verdict is registered straight into the output stage so RESP presents it.
        if (chk_out_valid) begin
          out_v_d     = 1'b1;
          out_own_d   = owner_q;
          out_legal_d = chk_out_legal_id;
          state_d     = RESP;
        end else if (timer_q == LAST_TICK) begin
          out_v_d   = 1'b1;
          out_own_d = owner_q;
          out_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= RST_OWNER;
      cnt_q        <= '0;
      timer_q      <= '0;
      chk_v_q      <= 1'b0;
      chk_id_q     <= '0;
      out_v_q      <= 1'b0;
      out_own_q    <= '0;
      out_legal_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      chk_v_q      <= chk_v_d;
      chk_id_q     <= chk_id_d;
      out_v_q      <= out_v_d;
      out_own_q    <= out_own_d;
      out_legal_q  <= out_legal_d;
      out_err_q    <= out_err_d;
    end
  end

  assign grant        = grant_q;
  assign chk_in_valid = chk_v_q;
  assign chk_in_id    = chk_id_q;
  assign out_valid    = out_v_q;
  assign out_owner    = out_own_q;
  assign out_legal_id = out_legal_q;
  assign out_err      = out_err_q;

endmodule

// File: tb/tb_idc_sched.sv
// Scoreboard bench for idc_sched: frame-level reference model feeds expected
// symbol and result queues that a negedge monitor drains.
module tb_idc_sched;
  localparam int NR  = 4;
  localparam int NS  = 10;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] in_valid;
  logic [6*NR-1:0] in_id;
  logic [NR-1:0] grant;
  logic          chk_in_valid;
  logic [5:0]    chk_in_id;
  logic          chk_out_valid;
  logic          chk_out_legal_id;
  logic          out_valid;
  logic [2:0]    out_owner;
  logic          out_legal_id;
  logic          out_err;

  idc_sched #(.N_REQ(NR), .N_SYM(NS), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .in_valid        (in_valid),
    .in_id           (in_id),
    .grant           (grant),
    .chk_in_valid    (chk_in_valid),
    .chk_in_id       (chk_in_id),
    .chk_out_valid   (chk_out_valid),
    .chk_out_legal_id(chk_out_legal_id),
    .out_valid       (out_valid),
    .out_owner       (out_owner),
    .out_legal_id    (out_legal_id),
    .out_err         (out_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] id; int gap; } sym_t;
  typedef struct { int own; int lg; int er; } res_t;

  sym_t sym_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_last = NR - 1;
  int   fwd_cnt = 0;
  int   run = 0;
  logic prev_ov = 1'b0;
  sym_t mon_s;
  res_t mon_r;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Round-robin winner: first requesting index after the previous owner, wrapping.
  function automatic int rr(input logic [NR-1:0] r, input int last);
    for (int off = 1; off <= NR; off++) begin
      int i;
      i = (last + off) % NR;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_in_valid) begin
      fwd_cnt++;
      if (sym_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sym_unexpected actual=%0d expected=none", chk_in_id);
      end else begin
        mon_s = sym_q.pop_front();
        chk("sym_id", chk_in_id, mon_s.id);
        if (mon_s.gap >= 0) chk("sym_gap", run, mon_s.gap);
      end
      run = 0;
    end else begin
      run++;
    end
    if (out_valid) begin
      chk("out_pulse_single", prev_ov, 0);
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL res_unexpected actual=%0d expected=none", out_owner);
      end else begin
        mon_r = res_q.pop_front();
        chk("out_owner", out_owner, mon_r.own);
        chk("out_legal", out_legal_id, mon_r.lg);
        chk("out_err", out_err, mon_r.er);
      end
    end else begin
      chk("out_zero_when_idle", {out_owner, out_legal_id, out_err}, 0);
    end
    prev_ov = out_valid;
  end

  task automatic run_frame(input logic [NR-1:0] rq, input int stall_pct, input int gap_at,
                           input int d, input logic lg, input bit drop_req,
                           input bit seq_syms, input int abort_at);
    int w, acc, stall, n, lat, gap_left, lat_e;
    logic v;
    logic [5:0] s;
    logic [NR-1:0] iv;
    logic [6*NR-1:0] idw;
    res_t r;
    w = rr(rq, model_last);
    fwd_cnt = 0;
    req = rq;
    n = 0;
    while (grant == '0 && n < 20) begin
      chk_out_valid = 1'($urandom); chk_out_legal_id = 1'($urandom);
      @(posedge clk); #1; n++;
    end
    chk("grant_wait", int'(n < 20), 1);
    if (n >= 20) return;
    chk("grant", grant, 1 << w);
    acc = 0; stall = 0; n = 0; gap_left = 3;
    while (acc < NS && n < 200) begin
      chk("grant_hold", grant, 1 << w);
      if (drop_req && acc == 3) req = '0;
      v = ($urandom_range(0, 99) >= stall_pct);
      if (gap_at >= 0 && acc == gap_at && gap_left > 0) begin v = 1'b0; gap_left--; end
      iv = NR'($urandom); iv[w] = v;
      idw = (6*NR)'($urandom);
      s = seq_syms ? ((acc == 0) ? 6'd10 : 6'(acc)) : 6'($urandom);
      idw[w*6 +: 6] = s;
      in_valid = iv; in_id = idw;
      chk_out_valid = 1'($urandom); chk_out_legal_id = 1'($urandom);
      @(posedge clk);
      if (v) begin
        sym_q.push_back('{s, (acc == 0) ? -1 : stall});
        acc++; stall = 0;
      end else if (acc > 0) begin
        stall++;
      end
      n++;
      #1;
      if (abort_at > 0 && acc == abort_at) begin
        rst_n = 1'b0;
        sym_q.delete();
        #1;
        chk("rst_async_outputs", {grant, chk_in_valid, chk_in_id, out_valid, out_owner,
                                  out_legal_id, out_err}, 0);
        req = '0; in_valid = '0; chk_out_valid = 1'b0;
        model_last = NR - 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_grant", grant, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_grant", grant, 0);
        return;
      end
    end
    chk("stream_done", acc, NS);
    chk("grant_drop", grant, 0);
    in_valid = '0; chk_out_valid = 1'b0;
    if (d < TMO) begin r = '{w, int'(lg), 0}; lat_e = d + 1; end
    else begin r = '{w, 0, 1}; lat_e = TMO; end
    res_q.push_back(r);
    model_last = w;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk_out_valid = (lat == d);
      chk_out_legal_id = (lat == d) ? lg : 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    chk_out_valid = 1'b0;
    chk("result_latency", lat, lat_e);
    chk("fwd_count", fwd_cnt, NS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; in_valid = '0; in_id = '0;
    chk_out_valid = 1'b0; chk_out_legal_id = 1'b0;
    #2;
    chk("reset_outputs", {grant, chk_in_valid, chk_in_id, out_valid, out_owner,
                          out_legal_id, out_err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset_grant", grant, 0);

    for (int k = 0; k < 4; k++) run_frame('1, 0, -1, 1, 1'b1, 1'b0, 1'b0, 0);
    run_frame(4'b0001, 0, -1, 2, 1'b1, 1'b0, 1'b1, 0);
    run_frame(4'b0100, 0, 5, 1, 1'b0, 1'b0, 1'b0, 0);
    run_frame(4'b1000, 0, -1, TMO + 5, 1'b1, 1'b0, 1'b0, 0);
    run_frame(4'b0010, 20, -1, TMO - 1, 1'b1, 1'b1, 1'b0, 0);
    run_frame('1, 0, -1, 0, 1'b1, 1'b0, 1'b0, 5);
    run_frame('1, 0, -1, 3, 1'b1, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_frame(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(0, 50), -1,
                $urandom_range(0, TMO + 2), 1'($urandom), 1'($urandom), 1'b0, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sym_queue_drained", sym_q.size(), 0);
    chk("res_queue_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
